// File: rtl/uart_rx_if.sv
// Peripheral read/write strobe bus between the CPU address decoder and uart_rx.
interface uart_rx_if;
  logic [1:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;

  modport master (output addr, rd_en, wr_en, wr_data, input rd_data, rd_valid);
  modport slave  (input addr, rd_en, wr_en, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with receive FIFO, polled through DATA/STATUS/LEVEL registers.
module uart_rx #(
  parameter int unsigned DIVISOR    = 104,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus,
  input  logic      rx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_BIT = 16'(DIVISOR / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(DIVISOR - 1);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  state_t state, state_next;

  logic        rx_meta, rx_sync, rx_prev;
  logic        fall;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;

  logic cnt_load_half, cnt_load_full, cnt_dec, bit_shift, idx_clr;
  logic push_req, framing_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic          pop, flush, push_ok, overrun_set;
  logic          overrun, framing, clr_overrun, clr_framing;
  logic          not_empty, full;
  logic [15:0]   count_w;
  logic [7:0]    level;
  logic [7:0]    rd_next;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^{bus.wr_data[7:4], bus.wr_data[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (fall) state_next = S_START;
      S_START:     if (cnt == '0) state_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:      if (cnt == '0 && idx == 3'd7) state_next = S_STOP;
      S_STOP:      if (cnt == '0) state_next = rx_sync ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_sync) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_load_half = 1'b0;
    cnt_load_full = 1'b0;
    cnt_dec       = 1'b0;
    bit_shift     = 1'b0;
    idx_clr       = 1'b0;
    push_req      = 1'b0;
    framing_set   = 1'b0;
    unique case (state)
      S_IDLE:  cnt_load_half = fall;
      S_START: begin
        cnt_dec       = (cnt != '0);
        cnt_load_full = (cnt == '0) && !rx_sync;
        idx_clr       = (cnt == '0);
      end
      S_DATA: begin
        cnt_dec       = (cnt != '0);
        cnt_load_full = (cnt == '0);
        bit_shift     = (cnt == '0);
      end
      S_STOP: begin
        cnt_dec     = (cnt != '0);
        push_req    = (cnt == '0) && rx_sync;
        framing_set = (cnt == '0) && !rx_sync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (cnt_load_half)      cnt <= HALF_BIT;
      else if (cnt_load_full) cnt <= FULL_BIT;
      else if (cnt_dec)       cnt <= cnt - 16'd1;
      if (idx_clr) idx <= '0;
      else if (bit_shift) begin
        shreg[idx] <= rx_sync;
        idx        <= idx + 3'd1;
      end
    end
  end

  // A full FIFO still accepts a byte when a DATA read frees the head slot in the same cycle.
  assign pop         = bus.rd_en && bus.addr == 2'd0 && count != '0;
  assign flush       = bus.wr_en && bus.addr == 2'd2;
  assign push_ok     = push_req && !flush && (count != DEPTH_C || pop);
  assign overrun_set = push_req && !flush && count == DEPTH_C && !pop;
  assign clr_overrun = bus.wr_en && bus.addr == 2'd1 && bus.wr_data[2];
  assign clr_framing = bus.wr_en && bus.addr == 2'd1 && bus.wr_data[3];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      if (overrun_set)      overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (framing_set)      framing <= 1'b1;
      else if (clr_framing) framing <= 1'b0;
    end
  end

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_C);
  assign count_w   = 16'(count);
  assign level     = (count_w > 16'd255) ? 8'hFF : count_w[7:0];

  always_comb begin
    rd_next = '0;
    unique case (bus.addr)
      2'd0:    rd_next = not_empty ? mem[rptr] : '0;
      2'd1:    rd_next = {4'b0000, framing, overrun, full, not_empty};
      2'd2:    rd_next = level;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=8, FIFO_DEPTH=16.
module tb_uart_rx;
  localparam int unsigned DIV   = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  int checks   = 0;
  int failures = 0;

  uart_rx_if bus();

  uart_rx #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .rx  (rx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    chk({tag, ".valid"}, {7'd0, bus.rd_valid}, 8'h01);
    chk(tag, bus.rd_data, exp);
    @(posedge clk); #1;
    chk({tag, ".valid_drop"}, {7'd0, bus.rd_valid}, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  // Drives one 10-bit frame, 8 cycles per bit. With pop set, a DATA read is
  // strobed so that it lands on the same edge as the stop-bit push.
  task automatic send(input logic [7:0] d, input logic stop_bit, input bit pop,
                      input logic [7:0] exp_pop);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      rx = fr[c/8];
      if (pop && c == 78) begin
        bus.addr  = 2'd0;
        bus.rd_en = 1'b1;
      end
      if (pop && c == 79) begin
        bus.rd_en = 1'b0;
        chk("pop_on_push.valid", {7'd0, bus.rd_valid}, 8'h01);
        chk("pop_on_push.data", bus.rd_data, exp_pop);
      end
    end
  endtask

  initial begin
    logic [9:0] fr;
    bus.addr    = 2'd0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    tick(3);
    rst = 1'b0;
    chk("reset.rd_valid", {7'd0, bus.rd_valid}, 8'h00);
    chk("reset.rd_data", bus.rd_data, 8'h00);
    tick(4);
    rd(2'd1, 8'h00, "idle.status");
    rd(2'd2, 8'h00, "idle.level");
    rd(2'd0, 8'h00, "idle.data_empty");
    rd(2'd3, 8'h00, "idle.addr3");

    send(8'h55, 1'b1, 0, 8'h00);
    rd(2'd1, 8'h01, "b55.status");
    rd(2'd2, 8'h01, "b55.level");
    wr(2'd0, 8'hFF);
    rd(2'd2, 8'h01, "b55.level_after_data_write");
    rd(2'd0, 8'h55, "b55.data");
    rd(2'd1, 8'h00, "b55.status_after");

    send(8'hA3, 1'b1, 0, 8'h00);
    send(8'h0F, 1'b1, 0, 8'h00);
    send(8'hFF, 1'b1, 0, 8'h00);
    rd(2'd2, 8'h03, "b2b.level");
    rd(2'd0, 8'hA3, "b2b.data0");
    rd(2'd0, 8'h0F, "b2b.data1");
    rd(2'd0, 8'hFF, "b2b.data2");
    rd(2'd0, 8'h00, "b2b.data_empty");
    rd(2'd2, 8'h00, "b2b.level_empty");

    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 0, 8'h00);
    rd(2'd1, 8'h07, "ovr.status");
    rd(2'd2, 8'h10, "ovr.level");
    wr(2'd1, 8'h08);
    rd(2'd1, 8'h07, "ovr.status_w1c_other_bit");
    for (int i = 0; i < 16; i++) rd(2'd0, 8'(i), "ovr.data");
    rd(2'd0, 8'h00, "ovr.data_no_0x10");
    rd(2'd1, 8'h04, "ovr.status_sticky");
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h00, "ovr.status_cleared");

    send(8'h11, 1'b1, 0, 8'h00);
    rd(2'd2, 8'h01, "flush.level_before");
    wr(2'd2, 8'h00);
    rd(2'd2, 8'h00, "flush.level_after");
    rd(2'd1, 8'h00, "flush.status_after");

    send(8'h3C, 1'b0, 0, 8'h00);
    tick(20 * DIV);
    rx = 1'b1;
    tick(2 * DIV);
    rd(2'd1, 8'h08, "frm.status");
    rd(2'd2, 8'h00, "frm.level");
    wr(2'd1, 8'h08);
    rd(2'd1, 8'h00, "frm.status_cleared");
    send(8'h42, 1'b1, 0, 8'h00);
    rd(2'd2, 8'h01, "frm.level_next");
    rd(2'd0, 8'h42, "frm.data_next");

    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(5 * DIV);
    rd(2'd2, 8'h00, "glitch.level");
    rd(2'd1, 8'h00, "glitch.status");

    fr = {1'b1, 8'h99, 1'b0};
    for (int c = 0; c < 44; c++) begin
      @(posedge clk); #1;
      rx = fr[c/8];
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rx  = 1'b1;
    tick(4 * DIV);
    rd(2'd2, 8'h00, "rstmid.level");
    send(8'h99, 1'b1, 0, 8'h00);
    rd(2'd2, 8'h01, "rstmid.level_after");
    send(8'h5A, 1'b1, 1, 8'h99);
    rd(2'd2, 8'h01, "concurrent.level");
    rd(2'd0, 8'h5A, "concurrent.data");
    rd(2'd1, 8'h00, "concurrent.status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
